// File: rtl/bus_pkg.sv
// Shared definitions for the round-robin bus arbiter: FSM encoding and an
// index-width helper usable in constant expressions.
package bus_pkg;

    typedef enum logic {
        StIdle  = 1'b0,
        StOwned = 1'b1
    } arb_state_e;

    // Ceiling log2; returns 0 for n <= 1.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(n)) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/bus_switch.sv
// Word selector: routes requester word S of a packed data bus to the output.
module bus_switch
    import bus_pkg::*;
#(
    parameter int unsigned SIZE       = 8,
    parameter int unsigned DATA_WIDTH = 16
) (
    input  logic [SIZE*DATA_WIDTH-1:0] data_in,
    input  logic [clog2(SIZE)-1:0]     S,
    output logic [DATA_WIDTH-1:0]      data_out
);

    localparam int unsigned IW = clog2(SIZE);

    always_comb begin
        data_out = '0;
        for (int unsigned i = 0; i < SIZE; i++) begin
            if (S == IW'(i)) begin
                data_out = data_in[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin bus arbiter with one idle turnaround cycle between tenures.
// Optional tenure limit and timeout pulse are enabled by ARB_TIMEOUT_EN.
module bus_arbiter
    import bus_pkg::*;
#(
    parameter int unsigned SIZE       = 8,
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned TIMEOUT    = 16
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [SIZE-1:0]            req,
    input  logic [SIZE*DATA_WIDTH-1:0] data_in,
    output logic [SIZE-1:0]            gnt,
    output logic [clog2(SIZE)-1:0]     sel,
    output logic                       busy,
    output logic [DATA_WIDTH-1:0]      data_out
`ifdef ARB_TIMEOUT_EN
    ,
    output logic                       timeout
`endif
);

    localparam int unsigned IW = clog2(SIZE);

    if ((SIZE < 2) || (SIZE > 16) || ((SIZE & (SIZE - 1)) != 0)) begin : g_bad_size
        $error("bus_arbiter: SIZE must be a power of 2 in 2..16");
    end
    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("bus_arbiter: TIMEOUT must be at least 1");
    end

    arb_state_e     state_q, state_d;
    logic [IW-1:0]  sel_q, sel_d;
    logic [IW-1:0]  last_q, last_d;
    logic [IW-1:0]  cand, pick;
    logic           found;
    logic [DATA_WIDTH-1:0] sw_data;

`ifdef ARB_TIMEOUT_EN
    localparam int unsigned CW = clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    logic          timeout_q, timeout_d;
`endif

    // Search upward from last+1; offset SIZE wraps back to last itself,
    // so a lone requester equal to last is still found.
    always_comb begin
        found = 1'b0;
        pick  = last_q;
        cand  = last_q;
        for (int unsigned k = 1; k <= SIZE; k++) begin
            cand = last_q + IW'(k);
            if (!found && req[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        last_d  = last_q;
`ifdef ARB_TIMEOUT_EN
        cnt_d     = cnt_q;
        timeout_d = 1'b0;
`endif
        unique case (state_q)
            StIdle: begin
                if (found) begin
                    state_d = StOwned;
                    sel_d   = pick;
`ifdef ARB_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            StOwned: begin
                if (!req[sel_q]) begin
                    state_d = StIdle;
                    last_d  = sel_q;
                end
`ifdef ARB_TIMEOUT_EN
                else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    // Forced release: owner loses priority even with req held.
                    state_d   = StIdle;
                    last_d    = sel_q;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            sel_q   <= '0;
            last_q  <= IW'(SIZE - 1);
`ifdef ARB_TIMEOUT_EN
            cnt_q     <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
`ifdef ARB_TIMEOUT_EN
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
`endif
        end
    end

    assign busy = (state_q == StOwned);
    assign sel  = sel_q;

    always_comb begin
        gnt = '0;
        if (busy) begin
            gnt[sel_q] = 1'b1;
        end
    end

    bus_switch #(
        .SIZE       (SIZE),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_switch (
        .data_in  (data_in),
        .S        (sel_q),
        .data_out (sw_data)
    );

    assign data_out = busy ? sw_data : '0;

`ifdef ARB_TIMEOUT_EN
    assign timeout = timeout_q;
`endif

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed scenarios plus randomized
// traffic compared against a behavioural round-robin model.
module tb_bus_arbiter;

    localparam int SIZE = 8;
    localparam int DW   = 16;
    localparam int TO   = 16;
    localparam int IW   = 3;

    logic                 clk;
    logic                 reset_n;
    logic [SIZE-1:0]      req;
    logic [SIZE*DW-1:0]   data_in;
    logic [SIZE-1:0]      gnt;
    logic [IW-1:0]        sel;
    logic                 busy;
    logic [DW-1:0]        data_out;
`ifdef ARB_TIMEOUT_EN
    logic                 timeout;
`endif

    bus_arbiter #(
        .SIZE       (SIZE),
        .DATA_WIDTH (DW),
        .TIMEOUT    (TO)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .req      (req),
        .data_in  (data_in),
        .gnt      (gnt),
        .sel      (sel),
        .busy     (busy),
        .data_out (data_out)
`ifdef ARB_TIMEOUT_EN
        ,
        .timeout  (timeout)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Model: owner index (-1 when nobody owns), last owner, visible sel,
    // completed tenure cycles, and a pending timeout pulse.
    int m_owner;
    int m_last;
    int m_sel;
    int m_ten;
    bit m_to;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] word(input int i);
        return data_in[i*DW +: DW];
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_last  = SIZE - 1;
        m_sel   = 0;
        m_ten   = 0;
        m_to    = 1'b0;
    endtask

    task automatic model_step(input logic [SIZE-1:0] r);
        m_to = 1'b0;
        if (m_owner < 0) begin
            for (int k = 1; k <= SIZE; k++) begin
                int c;
                c = (m_last + k) % SIZE;
                if (r[c]) begin
                    m_owner = c;
                    m_sel   = c;
                    m_ten   = 0;
                    break;
                end
            end
        end else if (!r[m_owner]) begin
            m_last  = m_owner;
            m_owner = -1;
        end else begin
            m_ten++;
`ifdef ARB_TIMEOUT_EN
            if (m_ten == TO) begin
                m_last  = m_owner;
                m_owner = -1;
                m_to    = 1'b1;
            end
`endif
        end
    endtask

    task automatic check_outputs();
        logic [SIZE-1:0] e_gnt;
        logic [DW-1:0]   e_data;
        e_gnt  = '0;
        e_data = '0;
        if (m_owner >= 0) begin
            e_gnt[m_owner] = 1'b1;
            e_data         = word(m_owner);
        end
        check_eq("gnt", 32'(gnt), 32'(e_gnt));
        check_eq("sel", 32'(sel), 32'(m_sel));
        check_eq("busy", 32'(busy), 32'(m_owner >= 0));
        check_eq("data_out", 32'(data_out), 32'(e_data));
`ifdef ARB_TIMEOUT_EN
        check_eq("timeout", 32'(timeout), 32'(m_to));
`endif
    endtask

    // Inputs change 1 time unit after a rising edge; outputs are checked there too.
    task automatic step(input logic [SIZE-1:0] r);
        req = r;
        @(posedge clk);
        if (reset_n) model_step(r);
        #1;
        check_outputs();
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        model_reset();
        #1;
        check_outputs();
        @(posedge clk);
        #1;
        check_outputs();
        reset_n = 1'b1;
    endtask

    task automatic fixed_words();
        for (int i = 0; i < SIZE; i++) begin
            data_in[i*DW +: DW] = 16'h0110 + 16'(i) * 16'h1111;
        end
    endtask

    initial begin
        reset_n = 1'b1;
        req     = '0;
        fixed_words();
        model_reset();
        #2;
        do_reset();

        // Single requester 0 after reset.
        step(8'h01);
        check_eq("first_gnt", 32'(gnt), 32'h01);
        check_eq("first_sel", 32'(sel), 32'h0);
        check_eq("first_data", 32'(data_out), 32'h0110);
        step(8'h00);
        check_eq("turnaround_busy", 32'(busy), 32'h0);

        // All requesting, each owner dropping after 3 owned cycles.
        do_reset();
        for (int o = 0; o <= SIZE; o++) begin
            logic [SIZE-1:0] drop;
            drop = 8'hFF;
            drop[o % SIZE] = 1'b0;
            step(8'hFF);
            check_eq("rr_sel", 32'(sel), 32'(o % SIZE));
            step(8'hFF);
            step(8'hFF);
            step(drop);
            check_eq("rr_idle", 32'(busy), 32'h0);
        end

        // Owner 5 stable while req[2] toggles.
        step(8'h20);
        for (int i = 0; i < 6; i++) begin
            step((i % 2 == 0) ? 8'h24 : 8'h20);
            check_eq("hold_gnt", 32'(gnt), 32'h20);
            check_eq("hold_sel", 32'(sel), 32'h5);
        end
        step(8'h00);

        // Lone requester equal to last.
        step(8'h80);
        step(8'h00);
        step(8'h80);
        check_eq("lone_gnt", 32'(gnt), 32'h80);
        step(8'h00);

        // Asynchronous reset during owner 3's tenure.
        step(8'h08);
        step(8'h08);
        check_eq("pre_rst_gnt", 32'(gnt), 32'h08);
        reset_n = 1'b0;
        model_reset();
        #1;
        check_eq("async_gnt", 32'(gnt), 32'h0);
        check_eq("async_busy", 32'(busy), 32'h0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        step(8'h0C);
        check_eq("post_rst_gnt", 32'(gnt), 32'h04);
        check_eq("post_rst_sel", 32'(sel), 32'h2);
        step(8'h00);

`ifdef ARB_TIMEOUT_EN
        begin
            int owned0;
            int pulses;
            do_reset();
            owned0 = 0;
            pulses = 0;
            for (int i = 0; i < 60; i++) begin
                step(8'h03);
                if (gnt == 8'h01) owned0++;
                if (timeout) pulses++;
                if (gnt == 8'h02) break;
            end
            check_eq("to_tenure", 32'(owned0), 32'(TO));
            check_eq("to_pulses", 32'(pulses), 32'h1);
            check_eq("to_next", 32'(gnt), 32'h02);
            step(8'h00);
        end
`endif

        // Randomized traffic with occasional asynchronous resets.
        begin
            logic [SIZE-1:0] r;
            r = '0;
            for (int i = 0; i < 800; i++) begin
                for (int w = 0; w < SIZE * DW / 32; w++) begin
                    data_in[w*32 +: 32] = $urandom;
                end
                if ($urandom_range(0, 9) < 3) begin
                    r = 8'($urandom) & 8'($urandom);
                end
                if ($urandom_range(0, 99) == 0) begin
                    reset_n = 1'b0;
                    model_reset();
                    #1;
                    check_outputs();
                    @(posedge clk);
                    #1;
                    reset_n = 1'b1;
                end
                step(r);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
